// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: shares one memory port between fetch and data requesters.
// Optional fetch anti-starvation is enabled by defining ARB_FAIRNESS_EN.
module mem_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned MAX_WAIT     = 15,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall,
    output logic              timeout
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_GRANT_I = 2'd1;
    localparam logic [1:0] S_GRANT_D = 2'd2;

    localparam int unsigned WAIT_W = 8;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              w_arb;
    logic              w_grant_i;
    logic              w_grant_d;
    logic              w_ack;
    logic              w_expire;
    logic              w_force_i;
    logic [WAIT_W-1:0] r_wait;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_i_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_i_ready;
    logic              r_d_ready;
    logic              r_timeout;

    // The ready-pulse cycle never arbitrates: the finished requester still holds req.
    assign w_arb = (r_state == S_IDLE) && !(r_i_ready || r_d_ready);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_i   = 1'b0;
        w_grant_d   = 1'b0;
        w_ack       = 1'b0;
        w_expire    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_arb) begin
                    if (i_req && (w_force_i || !d_req)) begin
                        w_grant_i   = 1'b1;
                        w_state_nxt = S_GRANT_I;
                    end else if (d_req) begin
                        w_grant_d   = 1'b1;
                        w_state_nxt = S_GRANT_D;
                    end
                end
            end
            S_GRANT_I, S_GRANT_D: begin
                // Ack on the final wait cycle still wins over expiry.
                w_ack    = mem_ack;
                w_expire = !mem_ack && (r_wait == WAIT_W'(MAX_WAIT - 1));
                if (mem_ack || w_expire) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wait      <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
            r_i_ready   <= 1'b0;
            r_d_ready   <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_i_ready <= 1'b0;
            r_d_ready <= 1'b0;
            r_timeout <= 1'b0;
            if (w_grant_i || w_grant_d) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= w_grant_d & d_we;
                r_mem_addr  <= w_grant_d ? d_addr : i_addr;
                r_mem_wdata <= w_grant_d ? d_wdata : '0;
                r_wait      <= '0;
            end else if (w_ack || w_expire) begin
                r_mem_req <= 1'b0;
                r_mem_we  <= 1'b0;
                r_timeout <= w_expire;
                if (r_state == S_GRANT_I) begin
                    r_i_ready <= 1'b1;
                    r_i_rdata <= w_ack ? mem_rdata : '0;
                end else begin
                    r_d_ready <= 1'b1;
                    r_d_rdata <= w_ack ? mem_rdata : '0;
                end
            end else if (r_mem_req) begin
                r_wait <= r_wait + WAIT_W'(1);
            end
        end
    end

`ifdef ARB_FAIRNESS_EN
    localparam int unsigned STARVE_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    logic [STARVE_W-1:0] r_starve;

    assign w_force_i = (r_starve == STARVE_W'(STARVE_LIMIT));

    // Counts data grants that bypassed a waiting fetch; saturates at the limit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_starve <= '0;
        end else if (w_arb && !i_req) begin
            r_starve <= '0;
        end else if (w_grant_i) begin
            r_starve <= '0;
        end else if (w_grant_d && !w_force_i) begin
            r_starve <= r_starve + STARVE_W'(1);
        end
    end
`else
    // A zero limit degenerates to fetch-first in either build.
    assign w_force_i = (STARVE_LIMIT == 0);
`endif

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign i_rdata   = r_i_rdata;
    assign d_rdata   = r_d_rdata;
    assign i_ready   = r_i_ready;
    assign d_ready   = r_d_ready;
    assign timeout   = r_timeout;
    assign stall     = (i_req & ~r_i_ready) | (d_req & ~r_d_ready);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (default MAX_WAIT=15, STARVE_LIMIT=4).
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ready;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        stall;
    logic        timeout;

    int n_cmp = 0;
    int n_err = 0;

    mem_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_ready   (i_ready),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ready   (d_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .stall     (stall),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
        tick; tick;
        n_cmp++;
        if ({i_ready, d_ready, mem_req, mem_we, timeout} !== 5'b0) begin
            n_err++; $display("FAIL reset_flags got %b want 00000", {i_ready, d_ready, mem_req, mem_we, timeout});
        end
        n_cmp++;
        if ({mem_addr, mem_wdata} !== 64'h0) begin
            n_err++; $display("FAIL reset_mem_bus got %h/%h want 0/0", mem_addr, mem_wdata);
        end
        n_cmp++;
        if ({i_rdata, d_rdata} !== 64'h0) begin
            n_err++; $display("FAIL reset_rdata got %h/%h want 0/0", i_rdata, d_rdata);
        end
        reset = 1'b1;
        tick; tick;
    endtask

    task automatic test_single_fetch;
        i_req = 1'b1; i_addr = 32'h40;
        tick;
        n_cmp++;
        if ({mem_req, mem_we, i_ready, stall} !== 4'b1001 || mem_addr !== 32'h40) begin
            n_err++; $display("FAIL fetch_grant got req/we/rdy/stall=%b addr=%h want 1001 addr=00000040",
                              {mem_req, mem_we, i_ready, stall}, mem_addr);
        end
        mem_ack = 1'b1; mem_rdata = 32'h20080005;
        tick;
        mem_ack = 1'b0;
        n_cmp++;
        if ({i_ready, mem_req, timeout, stall} !== 4'b1000 || i_rdata !== 32'h20080005) begin
            n_err++; $display("FAIL fetch_ready got rdy/req/to/stall=%b rdata=%h want 1000 rdata=20080005",
                              {i_ready, mem_req, timeout, stall}, i_rdata);
        end
        i_req = 1'b0;
        tick;
        n_cmp++;
        if (i_ready !== 1'b0 || i_rdata !== 32'h20080005) begin
            n_err++; $display("FAIL fetch_hold got rdy=%b rdata=%h want 0 rdata=20080005", i_ready, i_rdata);
        end
        tick;
    endtask

    task automatic test_collision;
        i_req = 1'b1; i_addr = 32'h44; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        tick;
        n_cmp++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h100 || stall !== 1'b1) begin
            n_err++; $display("FAIL coll_data_first got req=%b addr=%h stall=%b want 1 00000100 1", mem_req, mem_addr, stall);
        end
        mem_ack = 1'b1; mem_rdata = 32'h1111;
        tick;
        mem_ack = 1'b0;
        n_cmp++;
        if (d_ready !== 1'b1 || d_rdata !== 32'h1111 || mem_req !== 1'b0 || stall !== 1'b1) begin
            n_err++; $display("FAIL coll_d_ready got rdy=%b rdata=%h req=%b stall=%b want 1 00001111 0 1",
                              d_ready, d_rdata, mem_req, stall);
        end
        d_req = 1'b0;
        tick;
        n_cmp++;
        if (mem_req !== 1'b0 || stall !== 1'b1) begin
            n_err++; $display("FAIL coll_idle_gap got req=%b stall=%b want 0 1", mem_req, stall);
        end
        tick;
        n_cmp++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h44 || stall !== 1'b1) begin
            n_err++; $display("FAIL coll_fetch_grant got req=%b addr=%h stall=%b want 1 00000044 1", mem_req, mem_addr, stall);
        end
        mem_ack = 1'b1; mem_rdata = 32'h2222;
        tick;
        mem_ack = 1'b0;
        n_cmp++;
        if (i_ready !== 1'b1 || i_rdata !== 32'h2222 || stall !== 1'b0) begin
            n_err++; $display("FAIL coll_i_ready got rdy=%b rdata=%h stall=%b want 1 00002222 0", i_ready, i_rdata, stall);
        end
        i_req = 1'b0;
        tick; tick;
    endtask

    task automatic test_store;
        int bad;
        bad = 0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h8; d_wdata = 32'hDEADBEEF;
        tick;
        d_addr = 32'hFFF0; d_wdata = 32'h12345678;
        for (int k = 0; k < 3; k++) begin
            if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h8 || mem_wdata !== 32'hDEADBEEF || d_ready !== 1'b0)
                bad++;
            if (k == 2) begin
                mem_ack = 1'b1; mem_rdata = 32'h0BAD;
            end
            tick;
        end
        mem_ack = 1'b0;
        n_cmp++;
        if (bad !== 0) begin
            n_err++; $display("FAIL store_hold got %0d unstable cycles want 0", bad);
        end
        n_cmp++;
        if (d_ready !== 1'b1 || mem_req !== 1'b0 || timeout !== 1'b0) begin
            n_err++; $display("FAIL store_ready got rdy/req/to=%b want 100", {d_ready, mem_req, timeout});
        end
        d_req = 1'b0; d_we = 1'b0;
        tick; tick;
    endtask

    task automatic test_timeout;
        int hi;
        int early;
        hi = 0; early = 0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        tick;
        for (int k = 0; k < 15; k++) begin
            if (mem_req === 1'b1) hi++;
            if (d_ready !== 1'b0 || timeout !== 1'b0) early++;
            tick;
        end
        n_cmp++;
        if (hi !== 15 || early !== 0) begin
            n_err++; $display("FAIL timeout_window got hi=%0d early=%0d want 15 0", hi, early);
        end
        n_cmp++;
        if ({d_ready, timeout, mem_req} !== 3'b110 || d_rdata !== 32'h0) begin
            n_err++; $display("FAIL timeout_pulse got rdy/to/req=%b rdata=%h want 110 00000000",
                              {d_ready, timeout, mem_req}, d_rdata);
        end
        d_req = 1'b0;
        tick;
        n_cmp++;
        if (timeout !== 1'b0 || d_ready !== 1'b0) begin
            n_err++; $display("FAIL timeout_one_cycle got to=%b rdy=%b want 0 0", timeout, d_ready);
        end
        tick;
        // Ack arriving on the last allowed cycle must complete normally.
        d_req = 1'b1;
        tick;
        for (int k = 0; k < 15; k++) begin
            if (k == 14) begin
                mem_ack = 1'b1; mem_rdata = 32'h5555;
            end
            tick;
        end
        mem_ack = 1'b0;
        n_cmp++;
        if ({d_ready, timeout} !== 2'b10 || d_rdata !== 32'h5555) begin
            n_err++; $display("FAIL ack_at_limit got rdy/to=%b rdata=%h want 10 00005555", {d_ready, timeout}, d_rdata);
        end
        d_req = 1'b0;
        tick; tick;
    endtask

    task automatic test_back_to_back;
        int ngr;
        int gcyc0;
        int gcyc1;
        logic [5:0] pat;
        logic [5:0] exp_pat;
        ngr = 0; gcyc0 = -1; gcyc1 = -1; pat = '0;
`ifdef ARB_FAIRNESS_EN
        exp_pat = 6'b010000;
`else
        exp_pat = 6'b000000;
`endif
        i_req = 1'b1; i_addr = 32'h44; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        for (int c = 0; c < 40 && ngr < 6; c++) begin
            mem_ack = mem_req; mem_rdata = 32'h0;
            if (mem_req === 1'b1) begin
                pat[ngr] = (mem_addr === 32'h44);
                if (ngr == 0) gcyc0 = c;
                if (ngr == 1) gcyc1 = c;
                ngr++;
            end
            tick;
        end
        mem_ack = 1'b0; i_req = 1'b0; d_req = 1'b0;
        n_cmp++;
        if (ngr !== 6) begin
            n_err++; $display("FAIL b2b_grant_count got %0d want 6", ngr);
        end
        n_cmp++;
        if (gcyc1 - gcyc0 !== 3) begin
            n_err++; $display("FAIL b2b_period got %0d want 3", gcyc1 - gcyc0);
        end
        n_cmp++;
        if (pat !== exp_pat) begin
            n_err++; $display("FAIL fairness_pattern got %b want %b", pat, exp_pat);
        end
        tick; tick; tick;
    endtask

    task automatic test_reset_mid;
        int pulses;
        pulses = 0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
        tick;
        n_cmp++;
        if (mem_req !== 1'b1) begin
            n_err++; $display("FAIL rstmid_grant got req=%b want 1", mem_req);
        end
        tick; tick;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (mem_req !== 1'b0) begin
            n_err++; $display("FAIL rstmid_async got req=%b want 0", mem_req);
        end
        d_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (d_ready !== 1'b0 || i_ready !== 1'b0) pulses++;
            tick;
        end
        reset = 1'b1;
        tick;
        if (d_ready !== 1'b0) pulses++;
        n_cmp++;
        if (pulses !== 0) begin
            n_err++; $display("FAIL rstmid_no_pulse got %0d pulses want 0", pulses);
        end
        i_req = 1'b1; i_addr = 32'h80;
        tick;
        n_cmp++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h80) begin
            n_err++; $display("FAIL rstmid_fresh_grant got req=%b addr=%h want 1 00000080", mem_req, mem_addr);
        end
        mem_ack = 1'b1; mem_rdata = 32'hABCD;
        tick;
        mem_ack = 1'b0;
        n_cmp++;
        if (i_ready !== 1'b1 || i_rdata !== 32'hABCD) begin
            n_err++; $display("FAIL rstmid_fresh_ready got rdy=%b rdata=%h want 1 0000abcd", i_ready, i_rdata);
        end
        i_req = 1'b0;
        tick; tick;
    endtask

    initial begin
        test_reset;
        test_single_fetch;
        test_collision;
        test_store;
        test_timeout;
        test_back_to_back;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired after %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter that lets the pipelined MIPS core run from one unified instruction/data memory. It accepts the fetch-stage request (PCF) and the memory-stage request (ALUOutM/WriteDataM/MemWriteM) and grants one at a time. It sequences the shared port through a grant FSM and returns per-requester ready pulses; the datapath stalls on these pulses. It sits between the core top level and the external memory. It replaces the separate ImmRD/DmmRD paths.

## Interface

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_WAIT, 15, cycles mem_req may stay high without mem_ack before timeout (1..255)
- STARVE_LIMIT, 4, consecutive data grants with fetch pending before fetch is forced (only with ARB_FAIRNESS_EN)

Ports (one clock `clk`; reset `reset` is asynchronous and active-low):
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- i_req  in  1  fetch request
- i_addr  in  ADDR_W  fetch address (PCF)
- i_rdata  out  DATA_W  instruction word, valid while i_ready=1
- i_ready  out  1  one-cycle completion pulse for fetch
- d_req  in  1  data request
- d_we  in  1  1=store, 0=load
- d_addr  in  ADDR_W  data address (ALUOutM)
- d_wdata  in  DATA_W  store data (WriteDataM)
- d_rdata  out  DATA_W  load data, valid while d_ready=1
- d_ready  out  1  one-cycle completion pulse for data
- mem_req  out  1  memory access strobe, held until ack or timeout
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, sampled with mem_ack
- mem_ack  in  1  memory completion, one cycle
- stall  out  1  combinational: (i_req & ~i_ready) | (d_req & ~d_ready)
- timeout  out  1  one-cycle pulse coincident with the ready pulse of an aborted access

## Operation

- FSM states: IDLE, GRANT_I, GRANT_D. Reset → IDLE.
- IDLE: if d_req, go to GRANT_D; else if i_req, go to GRANT_I; else stay. With both pending, data wins (older instruction), except under the fairness rule.
- On entering a grant, latch addr, we (0 for fetch) and wdata into internal registers. mem_* outputs drive these registers, so requester input changes mid-access have no effect.
- GRANT_x: mem_req=1. A wait counter increments each cycle. On mem_ack, capture mem_rdata into the x_rdata register, pulse x_ready next cycle, and return to IDLE.
- Timeout: if the wait counter reaches MAX_WAIT with no ack, drop mem_req, pulse x_ready and timeout together, set x_rdata=0, and return to IDLE. If ack and expiry occur in the same cycle, ack wins and there is no timeout.
- mem_ack in IDLE is ignored.
- Requester must hold req until its ready pulse. If req drops mid-grant, the access still completes and the pulse is still emitted.
- After any completion, the FSM returns to IDLE for exactly one cycle (mem_req=0) before the next grant.
- Stores: d_rdata receives mem_rdata anyway; the consumer ignores it.
- x_rdata registers hold their value between pulses.

## Timing

- Reset values: i_rdata=0, d_rdata=0, i_ready=0, d_ready=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, timeout=0. State is IDLE; all counters are 0.
- Request sampled high in cycle N (IDLE) → mem_req high from N+1.
- mem_ack in cycle M ≥ N+1 → ready pulse in M+1. Minimum latency is 2 cycles.
- Timeout: mem_req high for cycles N+1..N+MAX_WAIT; ready+timeout pulse in N+MAX_WAIT+1.
- Back-to-back throughput: one access per 3 cycles with zero-wait memory.
- Reset asserted mid-access forces IDLE immediately. mem_req drops asynchronously and no ready pulse is emitted.

## Configuration

- ARB_FAIRNESS_EN defined: a starvation counter (saturating at STARVE_LIMIT) increments on each data grant made while i_req=1. It clears on any fetch grant or when i_req=0 at arbitration. When the counter equals STARVE_LIMIT, the next IDLE arbitration with i_req=1 grants fetch even if d_req=1.
- ARB_FAIRNESS_EN undefined: strict data priority. The counter logic is absent and STARVE_LIMIT is unused.

## Test plan

- Single fetch: i_req=1, i_addr=0x40, memory acks 1 cycle after mem_req with 0x20080005 → mem_req N+1, i_ready and i_rdata=0x20080005 at N+2, mem_we=0.
- Load/fetch collision: both requests high in IDLE, d_addr=0x100 → d grant first (mem_addr=0x100). The fetch grant follows after the ready cycle plus one IDLE cycle. stall stays 1 until i_ready.
- Store: d_we=1, d_addr=0x8, d_wdata=0xDEADBEEF, 3-cycle memory wait → mem_we=1 with those values held stable for all 3 cycles, then d_ready.
- Timeout: d_req=1, memory never acks, MAX_WAIT=15 → mem_req high 15 cycles, then d_ready=timeout=1, d_rdata=0. Ack on cycle 15 → no timeout.
- Fairness (ARB_FAIRNESS_EN, STARVE_LIMIT=4): d_req and i_req held high → 4 data grants, then 1 fetch grant, then data resumes. Without the macro, the fetch is never granted.
- Reset mid-grant: assert reset during a 5-cycle wait → mem_req=0 immediately and no ready pulse. After release, a fresh request completes normally.
